port_uart_tx: RTL and testbench

//  Serial output stage downstream of the MIPS core's I/O port. Core stores to the output port
//  are presented as byte writes; this block buffers them in a small FIFO and shifts them out
//  as 8N1 UART frames on a single tx line. Lets software emit bytes without polling bit timing.

---
 rtl/port_uart_pkg.sv | 18 +
 rtl/port_fifo.sv | 70 +++++++
 rtl/port_uart_tx.sv | 156 +++++++++++++++
 tb/tb_port_uart_tx.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_uart_pkg.sv
// Shared types and constants for the core output port UART: FSM state encoding,
// frame geometry and the I/O addresses decoded by the core.
package port_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned UART_DATA_BITS = 8;

   // Core I/O decode: byte stores to TX_DATA enqueue, stores to STATUS clear overflow.
   localparam logic [31:0] PORT_TX_DATA_ADDR = 32'hFFFF_FF00;
   localparam logic [31:0] PORT_STATUS_ADDR  = 32'hFFFF_FF04;

endpackage

// File: rtl/port_fifo.sv
// Synchronous show-ahead FIFO: dout_o always presents the head entry; level is a
// separate counter so full/empty never depend on pointer comparison.
module port_fifo #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] din_i,
   output logic [DW-1:0] dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   level_o
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   level_q;
   logic [AW:0]   level_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (level_q == (AW + 1)'(DEPTH));
   assign empty_o = (level_q == '0);

   // Guards use the pre-edge level, so a push while full is lost even if a pop
   // frees a slot on the same edge.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      level_d = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + 1'b1;
      end else if (do_pop && !do_push) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/port_uart_tx.sv
// Core output port serialiser: queues byte stores in port_fifo and shifts them out
// as 8N1 frames, back-to-back while the queue is non-empty.
module port_uart_tx
   import port_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_AW      = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [7:0]         wr_data,
   input  logic               clr_ovf,
   output logic               tx,
   output logic               full,
   output logic               busy,
   output logic [FIFO_AW:0]   level,
   output logic               overflow
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

   uart_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             tx_q;
   logic             overflow_q;

   logic             cnt_end;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_dout;
   logic [FIFO_AW:0] fifo_level;
   logic             drop;

   port_fifo #(
      .DW (8),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (wr_en),
      .pop_i   (fifo_pop),
      .din_i   (wr_data),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign cnt_end = (cnt_q == CNT_LAST);
   assign drop    = wr_en && fifo_full;

   // The head is taken either from IDLE or at the very end of a stop bit, which
   // is what makes consecutive frames abut with no idle gap.
   always_comb begin
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: fifo_pop = !fifo_empty;
         ST_STOP: fifo_pop = cnt_end && !fifo_empty;
         default: fifo_pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (fifo_pop) begin
                  cnt_q   <= '0;
                  tx_q    <= 1'b0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_end) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
                  state_q   <= ST_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt_end) begin
                  cnt_q <= '0;
                  if (bit_idx_q == IDX_LAST) begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                     tx_q      <= shift_q[1];
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_STOP: begin
               if (cnt_end) begin
                  cnt_q <= '0;
                  if (fifo_pop) begin
                     tx_q    <= 1'b0;
                     state_q <= ST_START;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Shifter is pure datapath; it is reloaded on every pop so it needs no reset.
   always_ff @(posedge clk) begin
      if (fifo_pop) begin
         shift_q <= fifo_dout;
      end else if (state_q == ST_DATA && cnt_end && bit_idx_q != IDX_LAST) begin
         shift_q <= {1'b0, shift_q[7:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (clr_ovf) begin
         overflow_q <= 1'b0;
      end
   end

   assign tx       = tx_q;
   assign full     = fifo_full;
   assign level    = fifo_level;
   assign overflow = overflow_q;
   assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: a UART receiver decodes tx into a queue, written bytes
// are queued as expectations, and each scenario task compares both.
module tb_port_uart_tx;

   localparam int CPB   = 4;
   localparam int AW    = 2;
   localparam int FRAME = 10 * CPB;

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          clr_ovf;
   logic          tx;
   logic          full;
   logic          busy;
   logic [AW:0]   level;
   logic          overflow;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] data;
      logic       start_ok;
      logic       stop_ok;
      int         start_cyc;
   } rx_t;

   rx_t        rx_q[$];
   logic [7:0] exp_q[$];

   port_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_AW      (AW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .clr_ovf  (clr_ovf),
      .tx       (tx),
      .full     (full),
      .busy     (busy),
      .level    (level),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Receiver: start detected on a low negedge sample, bits taken mid-cell; a frame
   // interrupted by reset is discarded.
   initial begin : rx_mon
      rx_t  r;
      logic ab;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && tx === 1'b0) begin
            r.data = '0;
            r.start_ok = 1'b1;
            r.stop_ok = 1'b0;
            r.start_cyc = cyc;
            ab = 1'b0;
            for (int j = 1; j < FRAME; j++) begin
               @(negedge clk);
               if (reset !== 1'b1) begin
                  ab = 1'b1;
                  break;
               end
               if (j == CPB / 2 && tx !== 1'b0) r.start_ok = 1'b0;
               if (j >= CPB && j < 9 * CPB && (j % CPB) == CPB / 2) r.data[(j / CPB) - 1] = tx;
               if (j == 9 * CPB + CPB / 2) r.stop_ok = (tx === 1'b1);
            end
            if (!ab) rx_q.push_back(r);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

   task automatic put_byte(input logic [7:0] b, input bit scored);
      wr_en = 1'b1;
      wr_data = b;
      if (scored) exp_q.push_back(b);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget, output bit timed_out);
      int g = 0;
      while (rx_q.size() < n && g < budget) begin
         @(negedge clk);
         g++;
      end
      timed_out = (rx_q.size() < n);
   endtask

   task automatic wait_idle(input int budget);
      int g = 0;
      while (busy !== 1'b0 && g < budget) begin
         @(negedge clk);
         g++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wr_en = 1'b0;
      wr_data = 8'h00;
      clr_ovf = 1'b0;
      #2 reset = 1'b0;
      wr_en = 1'b1;
      wr_data = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (tx !== 1'b1 || busy !== 1'b0 || level !== '0 || overflow !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold[%0d]: tx=%b busy=%b level=%0d ovf=%b full=%b, want tx=1 busy=0 level=0 ovf=0 full=0",
                     i, tx, busy, level, overflow, full);
         end
      end
      wr_en = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || level !== '0) begin
         bad++;
         $display("FAIL reset_release: tx=%b busy=%b level=%0d, want 1 0 0", tx, busy, level);
      end
   endtask

   task automatic test_single();
      bit to;
      put_byte(8'hA5, 1'b1);
      total++;
      if (tx !== 1'b1 || level !== 3'd1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_push: tx=%b level=%0d busy=%b, want 1 1 1", tx, level, busy);
      end
      @(negedge clk);
      total++;
      if (tx !== 1'b0 || level !== 3'd0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_start: tx=%b level=%0d busy=%b, want 0 0 1", tx, level, busy);
      end
      repeat (FRAME - 1) @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_stop: tx=%b busy=%b, want 1 1", tx, busy);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || level !== 3'd0 || tx !== 1'b1) begin
         bad++;
         $display("FAIL single_done: busy=%b level=%0d tx=%b, want 0 0 1", busy, level, tx);
      end
      wait_rx(1, 10, to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL single_timeout: frames=%0d, want 1", rx_q.size());
      end
      while (exp_q.size() > 0) begin
         rx_t r;
         logic [7:0] e;
         e = exp_q.pop_front();
         total++;
         if (rx_q.size() == 0) begin
            bad++;
            $display("FAIL single_rx: no frame, want %02h", e);
         end else begin
            r = rx_q.pop_front();
            if (r.data !== e || r.start_ok !== 1'b1 || r.stop_ok !== 1'b1) begin
               bad++;
               $display("FAIL single_rx: got %02h start=%b stop=%b, want %02h start=1 stop=1",
                        r.data, r.start_ok, r.stop_ok, e);
            end
         end
      end
      wait_idle(100);
   endtask

   task automatic test_burst();
      bit to;
      int st[5];
      int n;
      for (int i = 1; i <= 5; i++) put_byte(8'(i), 1'b1);
      total++;
      if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL burst_fill: full=%b level=%0d ovf=%b, want 1 4 0", full, level, overflow);
      end
      wait_rx(5, 6 * FRAME, to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL burst_timeout: frames=%0d, want 5", rx_q.size());
      end
      n = 0;
      while (exp_q.size() > 0) begin
         rx_t r;
         logic [7:0] e;
         e = exp_q.pop_front();
         total++;
         if (rx_q.size() == 0) begin
            bad++;
            $display("FAIL burst_rx: no frame, want %02h", e);
         end else begin
            r = rx_q.pop_front();
            if (n < 5) st[n] = r.start_cyc;
            n++;
            if (r.data !== e || r.start_ok !== 1'b1 || r.stop_ok !== 1'b1) begin
               bad++;
               $display("FAIL burst_rx: got %02h start=%b stop=%b, want %02h start=1 stop=1",
                        r.data, r.start_ok, r.stop_ok, e);
            end
         end
      end
      if (n == 5) begin
         for (int i = 1; i < 5; i++) begin
            total++;
            if (st[i] - st[i-1] != FRAME) begin
               bad++;
               $display("FAIL burst_gap[%0d]: spacing=%0d cycles, want %0d", i, st[i] - st[i-1], FRAME);
            end
         end
      end
      wait_idle(100);
      total++;
      if (busy !== 1'b0 || level !== 3'd0 || full !== 1'b0) begin
         bad++;
         $display("FAIL burst_idle: busy=%b level=%0d full=%b, want 0 0 0", busy, level, full);
      end
   endtask

   task automatic test_overflow();
      bit to;
      put_byte(8'hC3, 1'b1);
      @(negedge clk);
      put_byte(8'h11, 1'b1);
      put_byte(8'h22, 1'b1);
      put_byte(8'h33, 1'b1);
      put_byte(8'h44, 1'b1);
      total++;
      if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_fill: full=%b level=%0d ovf=%b, want 1 4 0", full, level, overflow);
      end
      put_byte(8'hFF, 1'b0);
      total++;
      if (overflow !== 1'b1 || level !== 3'd4) begin
         bad++;
         $display("FAIL ovf_drop: ovf=%b level=%0d, want 1 4", overflow, level);
      end
      repeat (3) @(negedge clk);
      total++;
      if (overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_sticky: ovf=%b, want 1", overflow);
      end
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear: ovf=%b, want 0", overflow);
      end
      clr_ovf = 1'b1;
      put_byte(8'hEE, 1'b0);
      clr_ovf = 1'b0;
      total++;
      if (overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_set_wins: ovf=%b, want 1", overflow);
      end
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      wait_rx(5, 6 * FRAME, to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL ovf_timeout: frames=%0d, want 5", rx_q.size());
      end
      while (exp_q.size() > 0) begin
         rx_t r;
         logic [7:0] e;
         e = exp_q.pop_front();
         total++;
         if (rx_q.size() == 0) begin
            bad++;
            $display("FAIL ovf_rx: no frame, want %02h", e);
         end else begin
            r = rx_q.pop_front();
            if (r.data !== e || r.start_ok !== 1'b1 || r.stop_ok !== 1'b1) begin
               bad++;
               $display("FAIL ovf_rx: got %02h start=%b stop=%b, want %02h start=1 stop=1",
                        r.data, r.start_ok, r.stop_ok, e);
            end
         end
      end
      wait_idle(100);
      total++;
      if (rx_q.size() != 0 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_extra: leftover frames=%0d ovf=%b, want 0 0", rx_q.size(), overflow);
      end
   endtask

   task automatic test_push_pop();
      bit to;
      int st[3];
      int n;
      put_byte(8'hA1, 1'b1);
      put_byte(8'hB2, 1'b1);
      total++;
      if (level !== 3'd1 || tx !== 1'b0) begin
         bad++;
         $display("FAIL pp_first: level=%0d tx=%b, want 1 0", level, tx);
      end
      repeat (FRAME - 1) @(negedge clk);
      total++;
      if (level !== 3'd1 || tx !== 1'b1) begin
         bad++;
         $display("FAIL pp_stop: level=%0d tx=%b, want 1 1", level, tx);
      end
      put_byte(8'h3C, 1'b1);
      total++;
      if (level !== 3'd1 || tx !== 1'b0) begin
         bad++;
         $display("FAIL pp_same_edge: level=%0d tx=%b, want 1 0", level, tx);
      end
      wait_rx(3, 4 * FRAME, to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL pp_timeout: frames=%0d, want 3", rx_q.size());
      end
      n = 0;
      while (exp_q.size() > 0) begin
         rx_t r;
         logic [7:0] e;
         e = exp_q.pop_front();
         total++;
         if (rx_q.size() == 0) begin
            bad++;
            $display("FAIL pp_rx: no frame, want %02h", e);
         end else begin
            r = rx_q.pop_front();
            if (n < 3) st[n] = r.start_cyc;
            n++;
            if (r.data !== e || r.start_ok !== 1'b1 || r.stop_ok !== 1'b1) begin
               bad++;
               $display("FAIL pp_rx: got %02h start=%b stop=%b, want %02h start=1 stop=1",
                        r.data, r.start_ok, r.stop_ok, e);
            end
         end
      end
      if (n == 3) begin
         total++;
         if (st[2] - st[0] != 2 * FRAME) begin
            bad++;
            $display("FAIL pp_gap: span=%0d cycles, want %0d", st[2] - st[0], 2 * FRAME);
         end
      end
      wait_idle(100);
   endtask

   task automatic test_reset_mid();
      bit to;
      bit seen_low;
      put_byte(8'h55, 1'b0);
      put_byte(8'h99, 1'b0);
      repeat (9) @(negedge clk);
      total++;
      if (tx !== 1'b0 || level !== 3'd1) begin
         bad++;
         $display("FAIL rst_mid_pre: tx=%b level=%0d, want 0 1", tx, level);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if (tx !== 1'b1 || level !== 3'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_async: tx=%b level=%0d busy=%b, want 1 0 0", tx, level, busy);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      seen_low = 1'b0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) seen_low = 1'b1;
      end
      total++;
      if (seen_low || rx_q.size() != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_residual: tx_low_seen=%b frames=%0d busy=%b, want 0 0 0",
                  seen_low, rx_q.size(), busy);
      end
      put_byte(8'h96, 1'b1);
      wait_rx(1, 2 * FRAME, to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL rst_mid_timeout: frames=%0d, want 1", rx_q.size());
      end
      while (exp_q.size() > 0) begin
         rx_t r;
         logic [7:0] e;
         e = exp_q.pop_front();
         total++;
         if (rx_q.size() == 0) begin
            bad++;
            $display("FAIL rst_mid_rx: no frame, want %02h", e);
         end else begin
            r = rx_q.pop_front();
            if (r.data !== e || r.start_ok !== 1'b1 || r.stop_ok !== 1'b1) begin
               bad++;
               $display("FAIL rst_mid_rx: got %02h start=%b stop=%b, want %02h start=1 stop=1",
                        r.data, r.start_ok, r.stop_ok, e);
            end
         end
      end
      wait_idle(100);
   endtask

   initial begin : main
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_push_pop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
